// File: rtl/chacha20_auth_pkg.sv
`default_nettype none
// ============================================================================
// Module : chacha20_auth_pkg
// Brief  : Widths, FSM encoding and ChaCha20 helpers for the tag verifier.
// Rev    : 1.0  initial release
// ============================================================================
package chacha20_auth_pkg;

    localparam int TAG_W   = 128;
    localparam int NONCE_W = 96;
    localparam int KEY_W   = 256;

    localparam logic [31:0] CHACHA_C0 = 32'h61707865;
    localparam logic [31:0] CHACHA_C1 = 32'h3320646e;
    localparam logic [31:0] CHACHA_C2 = 32'h79622d32;
    localparam logic [31:0] CHACHA_C3 = 32'h6b206574;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    // 10 double rounds, one quarter-round per clock
    localparam int QR_STEPS = 80;

    function automatic logic [31:0] chacha_const(input logic [1:0] idx);
        case (idx)
            2'd0:    chacha_const = CHACHA_C0;
            2'd1:    chacha_const = CHACHA_C1;
            2'd2:    chacha_const = CHACHA_C2;
            default: chacha_const = CHACHA_C3;
        endcase
    endfunction

    function automatic logic [127:0] quarter_round(input logic [127:0] abcd);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        {a, b, c, d} = abcd;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Word indices {a,b,c,d}: four column rounds then four diagonal rounds
    function automatic logic [15:0] qr_index(input logic [2:0] step);
        case (step)
            3'd0:    qr_index = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    qr_index = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    qr_index = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    qr_index = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    qr_index = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    qr_index = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    qr_index = {4'd2, 4'd7, 4'd8,  4'd13};
            default: qr_index = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/chacha20_compact.sv
`default_nettype none
// ============================================================================
// Module : chacha20_compact
// Brief  : Serial ChaCha20 block (one quarter-round per cycle); returns the
//          first 128 keystream bits XORed with plaintext, 81 cycles after start.
// Rev    : 1.0  initial release
// ============================================================================
module chacha20_compact
    import chacha20_auth_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KEY_W-1:0]   key,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [TAG_W-1:0]   plaintext,
    output logic               valid,
    output logic [TAG_W-1:0]   result
);

    logic [31:0]      r_x [16];
    logic [6:0]       r_step;
    logic             r_busy;
    logic             r_valid;
    logic [TAG_W-1:0] r_result;

    logic [3:0]       w_ia;
    logic [3:0]       w_ib;
    logic [3:0]       w_ic;
    logic [3:0]       w_id;
    logic [127:0]     w_qr;
    logic [TAG_W-1:0] w_out;

    always_comb begin
        {w_ia, w_ib, w_ic, w_id} = qr_index(r_step[2:0]);
        w_qr = quarter_round({r_x[w_ia], r_x[w_ib], r_x[w_ic], r_x[w_id]});
    end

    // Only words 0..3 are emitted, and their initial values are the constants
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out
            assign w_out[TAG_W-1-32*gi -: 32] =
                (r_x[gi] + chacha_const(2'(gi))) ^ plaintext[TAG_W-1-32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_step   <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            for (int i = 0; i < 16; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            if (start) begin
                // Key and nonce words are taken most-significant word first
                r_x[0] <= CHACHA_C0;
                r_x[1] <= CHACHA_C1;
                r_x[2] <= CHACHA_C2;
                r_x[3] <= CHACHA_C3;
                for (int i = 0; i < 8; i++) begin
                    r_x[4+i] <= key[KEY_W-1-32*i -: 32];
                end
                r_x[12] <= 32'd0;
                for (int i = 0; i < 3; i++) begin
                    r_x[13+i] <= nonce[NONCE_W-1-32*i -: 32];
                end
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_step == 7'(QR_STEPS)) begin
                    r_valid  <= 1'b1;
                    r_result <= w_out;
                    r_busy   <= 1'b0;
                end else begin
                    r_x[w_ia] <= w_qr[127:96];
                    r_x[w_ib] <= w_qr[95:64];
                    r_x[w_ic] <= w_qr[63:32];
                    r_x[w_id] <= w_qr[31:0];
                    r_step    <= r_step + 7'd1;
                end
            end
        end
    end

    assign valid  = r_valid;
    assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/chacha20_tag_verifier.sv
`default_nettype none
// ============================================================================
// Module : chacha20_tag_verifier
// Brief  : Challenge/response tag check using ChaCha20 with fail lockout.
//          Optional nonce replay guard: CHACHA20_REPLAY_GUARD_EN.
// Rev    : 1.0  initial release
// ============================================================================
module chacha20_tag_verifier
    import chacha20_auth_pkg::*;
#(
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic [KEY_W-1:0]   key,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [TAG_W-1:0]   challenge,
    input  logic [TAG_W-1:0]   tag,
    output logic               done,
    output logic               pass,
    output logic               locked
);

    localparam int                LCNT_W      = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [7:0]        c_MAX_FAILS = 8'(MAX_FAILS);
    localparam logic [LCNT_W-1:0] c_LOCK_LAST = LCNT_W'(LOCKOUT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [KEY_W-1:0]   r_key;
    logic [NONCE_W-1:0] r_nonce;
    logic [TAG_W-1:0]   r_challenge;
    logic [TAG_W-1:0]   r_tag;
    logic               r_done;
    logic               r_pass;
    logic               r_locked;
    logic [7:0]         r_fail_cnt;
    logic [LCNT_W-1:0]  r_lock_cnt;

    logic               w_admit;
    logic               w_lock_due;
    logic               w_core_start;
    logic               w_core_valid;
    logic [TAG_W-1:0]   w_core_result;
    logic               w_match;
    logic [7:0]         w_fail_inc;

`ifdef CHACHA20_REPLAY_GUARD_EN
    logic [NONCE_W-1:0] r_last_nonce;
    logic               r_have_last;

    assign w_admit = !r_have_last || (r_nonce > r_last_nonce);
`else
    assign w_admit = 1'b1;
`endif

    assign w_lock_due   = (r_fail_cnt >= c_MAX_FAILS);
    assign w_core_start = (r_state == ST_CHECK) && w_admit;
    // Full-width reduction: no data-dependent early exit
    assign w_match      = ~|(w_core_result ^ r_tag);
    assign w_fail_inc   = (r_fail_cnt == 8'hFF) ? r_fail_cnt : r_fail_cnt + 8'd1;

    chacha20_compact u_core (
        .clk       (clk),
        .rst_n     (~rst),
        .start     (w_core_start),
        .key       (r_key),
        .nonce     (r_nonce),
        .plaintext (r_challenge),
        .valid     (w_core_valid),
        .result    (w_core_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_key       <= '0;
            r_nonce     <= '0;
            r_challenge <= '0;
            r_tag       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_locked    <= 1'b0;
            r_fail_cnt  <= '0;
            r_lock_cnt  <= '0;
`ifdef CHACHA20_REPLAY_GUARD_EN
            r_last_nonce <= '0;
            r_have_last  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A rejected replay returns here with the lockout still pending
                    if (w_lock_due) begin
                        r_state    <= ST_LOCKED;
                        r_locked   <= 1'b1;
                        r_lock_cnt <= '0;
                    end else if (start) begin
                        r_key       <= key;
                        r_nonce     <= nonce;
                        r_challenge <= challenge;
                        r_tag       <= tag;
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_admit) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_done     <= 1'b1;
                        r_pass     <= 1'b0;
                        r_fail_cnt <= w_fail_inc;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_done) begin
                        r_state    <= w_lock_due ? ST_LOCKED : ST_IDLE;
                        r_locked   <= w_lock_due;
                        r_lock_cnt <= '0;
                    end else if (w_core_valid) begin
                        r_done     <= 1'b1;
                        r_pass     <= w_match;
                        r_fail_cnt <= w_match ? 8'd0 : w_fail_inc;
`ifdef CHACHA20_REPLAY_GUARD_EN
                        if (w_match) begin
                            r_last_nonce <= r_nonce;
                            r_have_last  <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    if (r_lock_cnt == c_LOCK_LAST) begin
                        r_state    <= ST_IDLE;
                        r_locked   <= 1'b0;
                        r_fail_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ready  = (r_state == ST_IDLE) && !w_lock_due;
    assign done   = r_done;
    assign pass   = r_pass;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_chacha20_tag_verifier.sv
`default_nettype none
// ============================================================================
// Module : tb_chacha20_tag_verifier
// Brief  : Scoreboard bench with a ChaCha20 reference model and a fail/lockout
//          model; follows CHACHA20_REPLAY_GUARD_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_chacha20_tag_verifier;

    localparam int MAXF = 3;
    localparam int LOCK = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         ready;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [127:0] challenge = '0;
    logic [127:0] tag = '0;
    logic         done;
    logic         pass;
    logic         locked;

    chacha20_tag_verifier #(.MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .key(key),
        .nonce(nonce), .challenge(challenge), .tag(tag), .done(done),
        .pass(pass), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic pass;
        int   cyc;
        logic lock_after;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int mon_seen = 0;

    int          m_fail = 0;
    logic [95:0] m_last = '0;
    bit          m_have = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] ref_qr(input logic [31:0] a0, input logic [31:0] b0,
                                            input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a += b; d ^= a; d = (d << 16) | (d >> 16);
        c += d; b ^= c; b = (b << 12) | (b >> 20);
        a += b; d ^= a; d = (d << 8)  | (d >> 24);
        c += d; b ^= c; b = (b << 7)  | (b >> 25);
        return {a, b, c, d};
    endfunction

    // First four words of the ChaCha20 block (counter 0) XOR challenge
    function automatic logic [127:0] ref_expected(input logic [255:0] k, input logic [95:0] n,
                                                  input logic [127:0] ch);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] q;
        logic [127:0] ks;
        int idx [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                           '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
        s[12] = 32'd0;
        for (int i = 0; i < 3; i++) s[13+i] = n[95-32*i -: 32];
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 8; j++) begin
                q = ref_qr(x[idx[j][0]], x[idx[j][1]], x[idx[j][2]], x[idx[j][3]]);
                x[idx[j][0]] = q[127:96];
                x[idx[j][1]] = q[95:64];
                x[idx[j][2]] = q[63:32];
                x[idx[j][3]] = q[31:0];
            end
        end
        ks = {x[0] + s[0], x[1] + s[1], x[2] + s[2], x[3] + s[3]};
        return ks ^ ch;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic scramble();
        key       = rnd256();
        nonce     = rnd256()[95:0];
        challenge = rnd256()[127:0];
        tag       = rnd256()[127:0];
    endtask

    // Waits for ready; start is pulsed with junk only in cycles where locked=1
    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 400) begin
            if (locked) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            w++;
        end
        start = 1'b0;
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic issue(input logic [255:0] k, input logic [95:0] n,
                         input logic [127:0] ch, input logic [127:0] tg);
        sb_item_t it;
        logic     admit;
        int       target;
        int       w;
        wait_ready();
        key = k; nonce = n; challenge = ch; tag = tg;
        start = 1'b1;
        admit = 1'b1;
`ifdef CHACHA20_REPLAY_GUARD_EN
        admit = !m_have || (n > m_last);
`endif
        it.pass = admit && (ref_expected(k, n, ch) == tg);
        it.cyc  = cyc + (admit ? 84 : 2);
        if (it.pass) begin
            m_fail = 0;
            m_last = n;
            m_have = 1;
        end else if (m_fail < 255) begin
            m_fail++;
        end
        it.lock_after = (m_fail >= MAXF);
        if (it.lock_after) m_fail = 0;
        target = mon_seen + 1;
        sb_q.push_back(it);
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (mon_seen < target && w < 300) begin
            scramble();
            @(negedge clk);
            w++;
        end
        if (mon_seen < target) check("response_timeout", 128'(mon_seen), 128'(target));
    endtask

    initial begin : monitor
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (!rst && done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    it = sb_q.pop_front();
                    check("verdict_pass", pass, it.pass);
                    check("done_cycle", 128'(cyc), 128'(it.cyc));
                    @(negedge clk);
                    check("done_single_pulse", done, 0);
                    check("pass_held", pass, it.pass);
                    check("ready_after_done", ready, !it.lock_after);
                    check("locked_after_done", locked, it.lock_after);
                    mon_seen++;
                    if (it.lock_after) begin
                        for (int j = 2; j <= LOCK; j++) begin
                            @(negedge clk);
                            check("locked_hold", locked, 1);
                            check("ready_in_lock", ready, 0);
                            check("no_done_in_lock", done, 0);
                        end
                        @(negedge clk);
                        check("locked_release", locked, 0);
                        check("ready_release", ready, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [127:0] zt;
        logic [127:0] e;
        logic [255:0] k;
        logic [127:0] ch;
        logic [95:0]  rn;
        int           t0;

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_locked", locked, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vector, then the same request with bit 0 flipped
        zt = 128'hade0b876_903df1a0_e56a5d40_28bd8653;
        issue('0, '0, '0, zt);
        issue('0, '0, '0, zt ^ 128'd1);

        // Replay pattern: nonce 5 passes, nonce 5 again, nonce 6
        k = rnd256(); ch = rnd256()[127:0];
        issue(k, 96'd5, ch, ref_expected(k, 96'd5, ch));
        issue(k, 96'd5, ch, ref_expected(k, 96'd5, ch));
        issue(k, 96'd6, ch, ref_expected(k, 96'd6, ch));

        // Three consecutive bad tags force lockout
        for (int i = 0; i < 3; i++) begin
            k = rnd256(); ch = rnd256()[127:0];
            e = ref_expected(k, 96'(7 + i), ch);
            issue(k, 96'(7 + i), ch, e ^ (128'd1 << $urandom_range(127, 0)));
        end

        // Randomised requests; occasional equal nonce exercises the guard
        rn = 96'd100;
        for (int i = 0; i < 30; i++) begin
            k = rnd256(); ch = rnd256()[127:0];
            rn = rn + 96'($urandom_range(2, 0));
            e = ref_expected(k, rn, ch);
            if ($urandom_range(9, 0) < 6) issue(k, rn, ch, e);
            else issue(k, rn, ch, e ^ (128'd1 << $urandom_range(127, 0)));
        end

        // Reset at cycle 40 of a request: no verdict, then a clean retry
        wait_ready();
        k = rnd256(); ch = rnd256()[127:0];
        key = k; nonce = 96'd3; challenge = ch; tag = ref_expected(k, 96'd3, ch);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", ready, 1);
        check("locked_after_rst", locked, 0);
        check("pass_after_rst", pass, 0);
        m_fail = 0;
        m_have = 0;
        repeat (100) @(negedge clk);
        issue(k, 96'd3, ch, ref_expected(k, 96'd3, ch));

        wait_ready();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
